// File: rtl/seg7_pkg.sv
// Shared types and constants for the multiplexed seven-segment scan driver.
// Holds the hex segment table (active-low, bit order {g,f,e,d,c,b,a}),
// the all-dark pattern and the segment bit-index enumeration.
// Optional feature macro used by the top: SEG7_LEADING_ZERO_BLANK_EN.
package seg7_pkg;

   localparam int unsigned SEG_W = 7;
   localparam int unsigned NIB_W = 4;

   typedef logic [NIB_W-1:0] nibble_t;
   typedef logic [SEG_W-1:0] seg_t;

   // Bit position of each segment inside a seg_t.
   typedef enum logic [2:0] {
      SEG_A = 3'd0,
      SEG_B = 3'd1,
      SEG_C = 3'd2,
      SEG_D = 3'd3,
      SEG_E = 3'd4,
      SEG_F = 3'd5,
      SEG_G = 3'd6
   } seg_idx_e;

   localparam seg_t SEG_OFF = 7'b1111111;

   // Active-low glyphs for 0..F, indexed by nibble value.
   localparam seg_t SEG_TABLE [16] = '{
      7'b1000000,  // 0
      7'b1111001,  // 1
      7'b0100100,  // 2
      7'b0110000,  // 3
      7'b0011001,  // 4
      7'b0010010,  // 5
      7'b0000010,  // 6
      7'b1111000,  // 7
      7'b0000000,  // 8
      7'b0010000,  // 9
      7'b0001000,  // A
      7'b0000011,  // b
      7'b1000110,  // C
      7'b0100001,  // d
      7'b0000110,  // E
      7'b0001110   // F
   };

endpackage : seg7_pkg

// File: rtl/seg7_encode.sv
// Combinational hex-nibble to seven-segment encoder.
// Ports:
//   nib_i   - 4-bit hex value
//   seg_c_o - 7-bit active-low pattern {g,f,e,d,c,b,a} (combinational)
module seg7_encode
   import seg7_pkg::*;
(
   input  logic [NIB_W-1:0] nib_i,
   output logic [SEG_W-1:0] seg_c_o
);

   // Straight table lookup.
   always_comb begin
      seg_c_o = SEG_TABLE[nib_i];
   end

endmodule : seg7_encode

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment display driver.
// A refresh divider splits time into slots of REFRESH_DIV cycles; each slot
// lights one digit, rotating 0..NUM_DIGITS-1. The first cycle of every slot
// has all anodes dark to avoid ghosting while segments switch.
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   data        - 4*NUM_DIGITS hex nibbles, digit 0 in bits [3:0]
//   dp, blank   - per-digit decimal point request / force-dark
//   load        - capture data/dp/blank into shadow registers
//   seg, dp_n   - active-low segment and decimal point drives (registered)
//   an          - active-low digit anodes (registered)
//   frame_tick  - one-cycle pulse after the last slot of a scan
// Optional: define SEG7_LEADING_ZERO_BLANK_EN to auto-blank leading zeros.
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int unsigned NUM_DIGITS  = 4,
   parameter int unsigned REFRESH_DIV = 50000
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NIB_W*NUM_DIGITS-1:0] data,
   input  logic [NUM_DIGITS-1:0]       dp,
   input  logic [NUM_DIGITS-1:0]       blank,
   input  logic                        load,
   output logic [SEG_W-1:0]            seg,
   output logic                        dp_n,
   output logic [NUM_DIGITS-1:0]       an,
   output logic                        frame_tick
);

   localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int unsigned DIV_W  = $clog2(REFRESH_DIV);
   localparam int unsigned DATA_W = NIB_W * NUM_DIGITS;

   logic [DIV_W-1:0]      div_q,   div_d;
   logic [IDX_W-1:0]      idx_q,   idx_d;
   logic [DATA_W-1:0]     data_q,  data_d;
   logic [NUM_DIGITS-1:0] dp_q,    dp_d;
   logic [NUM_DIGITS-1:0] blank_q, blank_d;
   logic [SEG_W-1:0]      seg_q,   seg_d;
   logic                  dpn_q,   dpn_d;
   logic [NUM_DIGITS-1:0] an_q,    an_d;
   logic                  ft_q,    ft_d;

   logic                  tc_c;
   logic                  last_c;
   logic [NIB_W-1:0]      nib_c;
   logic [SEG_W-1:0]      enc_c;
   logic                  dp_sel_c;
   logic                  blank_sel_c;
   logic                  lz_sel_c;
   logic [NUM_DIGITS-1:0] lz_c;

   assign tc_c   = (div_q == DIV_W'(REFRESH_DIV - 1));
   assign last_c = (idx_q == IDX_W'(NUM_DIGITS - 1));

   // Leading-zero suppression: digit i>0 goes dark while it and every higher
   // nibble are zero, unless its own decimal point is requested.
`ifdef SEG7_LEADING_ZERO_BLANK_EN
   logic hi_zero_c;
   always_comb begin
      lz_c      = '0;
      hi_zero_c = 1'b1;
      for (int i = int'(NUM_DIGITS) - 1; i >= 1; i--) begin
         hi_zero_c = hi_zero_c & (data_q[NIB_W*i +: NIB_W] == '0);
         lz_c[i]   = hi_zero_c & ~dp_q[i];
      end
   end
`else
   always_comb begin
      lz_c = '0;
   end
`endif

   // Select the shadow contents of the digit currently being scanned.
   always_comb begin
      nib_c       = '0;
      dp_sel_c    = 1'b0;
      blank_sel_c = 1'b0;
      lz_sel_c    = 1'b0;
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
         if (idx_q == IDX_W'(i)) begin
            nib_c       = data_q[NIB_W*i +: NIB_W];
            dp_sel_c    = dp_q[i];
            blank_sel_c = blank_q[i];
            lz_sel_c    = lz_c[i];
         end
      end
   end

   seg7_encode u_encode (
      .nib_i   (nib_c),
      .seg_c_o (enc_c)
   );

   // Next-state: divider, digit index, shadow capture and output image.
   always_comb begin
      div_d   = tc_c ? '0 : div_q + DIV_W'(1);
      idx_d   = idx_q;
      data_d  = data_q;
      dp_d    = dp_q;
      blank_d = blank_q;
      seg_d   = SEG_OFF;
      dpn_d   = 1'b1;
      an_d    = '1;
      ft_d    = tc_c & last_c;

      if (tc_c) begin
         idx_d = last_c ? '0 : idx_q + IDX_W'(1);
      end

      if (load) begin
         data_d  = data;
         dp_d    = dp;
         blank_d = blank;
      end

      if (!(blank_sel_c | lz_sel_c)) begin
         seg_d = enc_c;
         dpn_d = ~dp_sel_c;
      end

      // Anodes stay dark for the first cycle of each slot.
      if (div_q != '0) begin
         for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (idx_q == IDX_W'(i)) begin
               an_d[i] = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_q   <= '0;
         idx_q   <= '0;
         data_q  <= '0;
         dp_q    <= '0;
         blank_q <= '1;
         seg_q   <= SEG_OFF;
         dpn_q   <= 1'b1;
         an_q    <= '1;
         ft_q    <= 1'b0;
      end else begin
         div_q   <= div_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         dp_q    <= dp_d;
         blank_q <= blank_d;
         seg_q   <= seg_d;
         dpn_q   <= dpn_d;
         an_q    <= an_d;
         ft_q    <= ft_d;
      end
   end

   assign seg        = seg_q;
   assign dp_n       = dpn_q;
   assign an         = an_q;
   assign frame_tick = ft_q;

endmodule : seg7_scan_driver

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (NUM_DIGITS=4, REFRESH_DIV=4).
// The reference model derives every output from the number of cycles since
// reset (slot = k/4, position in slot = k%4) and a copy of the loaded values.
module tb_seg7_scan_driver;

   localparam int unsigned ND = 4;
   localparam int unsigned RD = 4;

   localparam logic [6:0] EXP_TAB [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   logic          clk = 1'b0;
   logic          rst;
   logic [15:0]   data;
   logic [3:0]    dp;
   logic [3:0]    blank;
   logic          load;
   logic [6:0]    seg;
   logic          dp_n;
   logic [3:0]    an;
   logic          frame_tick;

   int            vecs = 0;
   int            errs = 0;

   int            k;
   logic [15:0]   sh_data;
   logic [3:0]    sh_dp;
   logic [3:0]    sh_blank;
   logic [6:0]    e_seg;
   logic          e_dpn;
   logic [3:0]    e_an;
   logic          e_ft;

   always #5 clk = ~clk;

   seg7_scan_driver #(
      .NUM_DIGITS  (ND),
      .REFRESH_DIV (RD)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .data       (data),
      .dp         (dp),
      .blank      (blank),
      .load       (load),
      .seg        (seg),
      .dp_n       (dp_n),
      .an         (an),
      .frame_tick (frame_tick)
   );

   // One clock edge: predict outputs from pre-edge state, then check.
   task automatic tick();
      int  d;
      bit  dark;
      @(posedge clk);
      if (rst) begin
         k        = 0;
         sh_data  = 16'h0;
         sh_dp    = 4'h0;
         sh_blank = 4'hF;
         e_seg    = 7'b1111111;
         e_dpn    = 1'b1;
         e_an     = 4'hF;
         e_ft     = 1'b0;
      end else begin
         d = (k / 4) % 4;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
         dark = sh_blank[d] ||
                (d > 0 && ((sh_data >> (4 * d)) == 16'h0) && !sh_dp[d]);
`else
         dark = sh_blank[d];
`endif
         e_seg = dark ? 7'b1111111 : EXP_TAB[(sh_data >> (4 * d)) & 16'hF];
         e_dpn = dark ? 1'b1 : !sh_dp[d];
         e_an  = (k % 4 == 0) ? 4'hF : ~(4'b0001 << d);
         e_ft  = (k % 16 == 15);
         if (load) begin
            sh_data  = data;
            sh_dp    = dp;
            sh_blank = blank;
         end
         k++;
      end
      #1;
      vecs++;
      assert (seg === e_seg) else begin
         errs++;
         $error("FAIL seg k=%0d got %b want %b", k, seg, e_seg);
      end
      vecs++;
      assert (dp_n === e_dpn) else begin
         errs++;
         $error("FAIL dp_n k=%0d got %b want %b", k, dp_n, e_dpn);
      end
      vecs++;
      assert (an === e_an) else begin
         errs++;
         $error("FAIL an k=%0d got %b want %b", k, an, e_an);
      end
      vecs++;
      assert (frame_tick === e_ft) else begin
         errs++;
         $error("FAIL frame_tick k=%0d got %b want %b", k, frame_tick, e_ft);
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_load(input logic [15:0] d, input logic [3:0] p,
                          input logic [3:0] b);
      data  = d;
      dp    = p;
      blank = b;
      load  = 1'b1;
      tick();
      load  = 1'b0;
   endtask

   initial begin
      logic [15:0] mask;
      rst   = 1'b1;
      load  = 1'b0;
      data  = 16'h0;
      dp    = 4'h0;
      blank = 4'h0;
      k     = 0;

      // Reset state, and load during reset is ignored.
      run(2);
      data = 16'hFFFF; dp = 4'hF; blank = 4'h0; load = 1'b1;
      tick();
      load = 1'b0;
      rst  = 1'b0;
      run(8);

      // 0x1234 scan order and anti-ghost cycle.
      do_load(16'h1234, 4'h0, 4'h0);
      run(20);

      // Every hex value in digit 0.
      for (int v = 0; v < 16; v++) begin
         do_load(16'(v), 4'h0, 4'h0);
         run(15);
      end

      // Blanked digit 2, decimal point on digit 0.
      do_load(16'h89AB, 4'b0001, 4'b0100);
      run(20);

      // Free run, two frame ticks.
      run(32);

      // Load on terminal-count cycle.
      for (int i = 0; i < 4 && (k % 4) != 3; i++) tick();
      do_load(16'hCDEF, 4'b1010, 4'h0);
      run(8);

      // Reset in the middle of digit 2's slot.
      for (int i = 0; i < 16 && (k % 16) != 9; i++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      run(20);

      // Leading-zero case.
      do_load(16'h0050, 4'h0, 4'h0);
      run(20);
      do_load(16'h0000, 4'h0, 4'h0);
      run(16);
      do_load(16'h0050, 4'b0100, 4'h0);
      run(16);

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 3))
            0:       mask = 16'hFFFF;
            1:       mask = 16'h00FF;
            2:       mask = 16'h000F;
            default: mask = 16'h0F0F;
         endcase
         data  = 16'($urandom) & mask;
         dp    = 4'($urandom);
         blank = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
         load  = ($urandom_range(0, 3) == 0);
         rst   = ($urandom_range(0, 63) == 0);
         tick();
      end
      rst  = 1'b0;
      load = 1'b0;
      run(16);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule : tb_seg7_scan_driver

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of multiplexed digits; legal range 1..8.
REQ-002 Parameter REFRESH_DIV, default 50000, clock cycles per digit slot; legal range 2..2^20.
REQ-003 Port clk  input  1  single clock, all logic rising-edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port data  input  4*NUM_DIGITS  hex nibbles; digit i = data[4i+3:4i], digit 0 rightmost.
REQ-006 Port dp  input  NUM_DIGITS  decimal point request per digit, active-high.
REQ-007 Port blank  input  NUM_DIGITS  force digit i dark, active-high.
REQ-008 Port load  input  1  capture data/dp/blank into shadow registers.
REQ-009 Port seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-010 Port dp_n  output  1  decimal point segment, active-low.
REQ-011 Port an  output  NUM_DIGITS  digit anodes, active-low, at most one low.
REQ-012 Port frame_tick  output  1  one-cycle pulse at end of each full scan.

Function
REQ-013 Shadow registers SHALL update from data/dp/blank on the rising edge where load=1; displayed content SHALL depend only on shadow registers.
REQ-014 Divider SHALL count 0..REFRESH_DIV-1 and wrap to 0; terminal count SHALL advance digit index idx by 1, wrapping NUM_DIGITS-1 -> 0.
REQ-015 frame_tick SHALL be 1 for exactly the cycle after terminal count with idx=NUM_DIGITS-1; otherwise 0.
REQ-016 seg, dp_n, an SHALL be registered, 1-cycle latency from idx and shadow contents.
REQ-017 Anti-ghost: an SHALL be all-ones during divider count 0 of every slot; seg/dp_n SHALL already show the new digit in that cycle.
REQ-018 Hex encoding (active-low, g..a): 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010 6=0000010 7=1111000 8=0000000 9=0010000 A=0001000 b=0000011 C=1000110 d=0100001 E=0000110 F=0001110.
REQ-019 Blanked digit SHALL drive seg=1111111 and dp_n=1; its an bit still asserts in its slot.
REQ-020 dp_n SHALL equal ~dp_shadow[idx] unless digit blanked.
REQ-021 load coincident with slot advance: both SHALL take effect; the new slot shows newly loaded data one cycle later.
REQ-022 NUM_DIGITS=1: idx stays 0, frame_tick pulses every REFRESH_DIV cycles.

Reset
REQ-023 While rst=1 at a clock edge: divider=0, idx=0, shadow data=0, dp=0, blank=all-ones, seg=1111111, dp_n=1, an=all-ones, frame_tick=0.
REQ-024 rst asserted mid-slot or mid-frame SHALL abort the scan; first post-reset slot SHALL be digit 0 with full REFRESH_DIV length.
REQ-025 load during rst SHALL be ignored.

Configuration
REQ-026 Macro SEG7_LEADING_ZERO_BLANK_EN defined: digit i>0 SHALL be auto-blanked when its nibble and all higher nibbles are 0 and its dp is 0; digit 0 never auto-blanked.
REQ-027 Macro undefined: only the blank input controls blanking; zero nibbles display "0".

Structure
REQ-028 Package seg7_pkg SHALL hold the 16-entry segment table constant, SEG_OFF constant (1111111), and the segment-index typedef.
REQ-029 Combinational sub-module seg7_encode (nibble in, 7-bit active-low pattern out) SHALL implement REQ-018 and be instantiated once.
REQ-030 Top SHALL contain divider, idx counter, shadow registers, mux, blanking logic and output registers.

Verification (NUM_DIGITS=4, REFRESH_DIV=4)
REQ-031 Reset, then load data=0x1234, blank=0 -> an cycles 1110,1101,1011,0111 each 3 cycles after 1 all-off cycle; seg=4,3,2,1 patterns in order.
REQ-032 All 16 nibbles in digit 0 via load -> seg matches REQ-018 table, incl. 8=0000000, 9=0010000.
REQ-033 blank=0100, dp=0001 -> digit 2 slot seg=1111111, dp_n=1; digit 0 slot dp_n=0.
REQ-034 Free run 32 cycles -> frame_tick pulses exactly twice, 16 cycles apart; load on terminal-count cycle -> next slot shows new data.
REQ-035 rst pulsed mid digit 2 -> next cycle all outputs off; scan restarts at digit 0.
REQ-036 SEG7_LEADING_ZERO_BLANK_EN defined, data=0x0050 -> digits 3,2 dark, digits 1,0 show 5,0; macro undefined -> shows 0050.
